// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial-adder controller and its adder.
// SERIAL_ADD_OVF_EN enables the carry-out (ovf) path in the controller.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      CAPT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Carry-out recovered from the operand MSBs and the sum MSB.
   function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
   endfunction

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle between a client and serial_add_ctrl.
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;

   modport master (
      output in_valid, op_a, op_b, out_ready,
      input  in_ready, out_valid, sum
   );

   modport slave (
      input  in_valid, op_a, op_b, out_ready,
      output in_ready, out_valid, sum
   );
endinterface

// File: rtl/serial_add_top.sv
// Integration wrapper: controller plus serial adder sharing one WIDTH.
// SERIAL_ADD_OVF_EN exposes the controller's ovf port.
module serial_add_top
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   serial_add_ctrl_if.slave bus
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);
   logic             add_ctrl;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_result;

   serial_add_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .add_ctrl   (add_ctrl),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   serial_adder #(.WIDTH(WIDTH)) u_adder (
      .clk     (clk),
      .reset_n (reset_n),
      .ctrl    (add_ctrl),
      .a       (add_a),
      .b       (add_b),
      .result  (add_result)
   );
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: ctrl=0 loads a/b and clears carry, ctrl=1 adds one bit per cycle
// into the top of register A; after WIDTH shifts A holds the sum.
module serial_adder
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry_r;
   logic             sum_bit_s;

   // Full-add of the current LSBs with the stored carry.
   always_comb begin
      sum_bit_s = a_r[0] ^ b_r[0] ^ carry_r;
   end

   // Load or shift the operand registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
      end else if (!ctrl) begin
         a_r     <= a;
         b_r     <= b;
         carry_r <= 1'b0;
      end else begin
         a_r     <= {sum_bit_s, a_r[WIDTH-1:1]};
         b_r     <= {1'b0, b_r[WIDTH-1:1]};
         carry_r <= maj3(a_r[0], b_r[0], carry_r);
      end
   end

   assign result = a_r;
endmodule

// File: rtl/serial_add_ctrl.sv
// Handshake controller that sequences an external serial adder through load/shift/capture.
// SERIAL_ADD_OVF_EN adds the registered carry-out port ovf.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   serial_add_ctrl_if.slave bus,
   output logic             add_ctrl,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_result
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state_r;
   state_t           state_nx;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             add_ctrl_r;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_r;
`endif

   // Next-state decode.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE:    if (bus.in_valid) state_nx = LOAD;  else state_nx = IDLE;
         LOAD:    state_nx = SHIFT;
         SHIFT:   if (cnt_r == LAST) state_nx = CAPT; else state_nx = SHIFT;
         CAPT:    state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE; else state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   // State, counter, operand/result registers; outputs are registered from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sum_r       <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         add_ctrl_r  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_r       <= 1'b0;
`endif
      end else begin
         state_r     <= state_nx;
         in_ready_r  <= (state_nx == IDLE);
         out_valid_r <= (state_nx == DONE);
         add_ctrl_r  <= (state_nx == SHIFT);
         if (state_r == IDLE && bus.in_valid) begin
            a_q <= bus.op_a;
            b_q <= bus.op_b;
         end
         // Counter saturates at LAST so it never wraps while shifting.
         if (state_r == LOAD) begin
            cnt_r <= '0;
         end else if (state_r == SHIFT && cnt_r != LAST) begin
            cnt_r <= cnt_r + CW'(1);
         end
         if (state_r == CAPT) begin
            sum_r <= add_result;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r <= carry_out(a_q[WIDTH-1], b_q[WIDTH-1], add_result[WIDTH-1]);
`endif
         end
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.sum       = sum_r;
   assign add_ctrl      = add_ctrl_r;
   assign add_a         = a_q;
   assign add_b         = b_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf           = ovf_r;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with the serial adder attached (WIDTH=4).
// Checks ovf only when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             add_ctrl;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_result;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif

   int               n_cmp = 0;
   int               n_bad = 0;
   int               cyc   = 0;
   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH:0]   exp_pop;

   serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .add_ctrl   (add_ctrl),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   serial_adder #(.WIDTH(WIDTH)) u_adder (
      .clk     (clk),
      .reset_n (reset_n),
      .ctrl    (add_ctrl),
      .a       (add_a),
      .b       (add_b),
      .result  (add_result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pop and compare on every completed output handshake.
   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            exp_pop = exp_q.pop_front();
            check("sum", {28'd0, bus.sum}, {28'd0, exp_pop[WIDTH-1:0]});
`ifdef SERIAL_ADD_OVF_EN
            check("ovf", {31'd0, ovf}, {31'd0, exp_pop[WIDTH]});
`endif
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] s, input logic o);
      wait_ready();
      bus.op_a     = a;
      bus.op_b     = b;
      bus.in_valid = 1'b1;
      exp_q.push_back({o, s});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic op_timed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] s, input logic o);
      logic [5:0] ctrl_seq;
      logic [6:0] ov_seq;
      issue(a, b, s, o);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k < 6) ctrl_seq[k] = add_ctrl;
         ov_seq[k] = bus.out_valid;
      end
      check("add_ctrl_seq", {26'd0, ctrl_seq}, 32'b011110);
      check("out_valid_latency", {25'd0, ov_seq}, 32'b1000000);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !bus.in_ready) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_queue_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      int           n;
      logic         ov_any;
      logic [3:0]   va[4];
      logic [3:0]   vb[4];
      logic [3:0]   vs[4];
      logic         vo[4];
      int           t_acc[4];

      va = '{4'd1, 4'd4, 4'd15, 4'd6};
      vb = '{4'd2, 4'd4, 4'd15, 4'd9};
      vs = '{4'd3, 4'd8, 4'd14, 4'd15};
      vo = '{1'b0, 1'b0, 1'b1, 1'b0};

      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.out_ready = 1'b1;
      reset_n       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_add_ctrl", {31'd0, add_ctrl}, 32'd0);
      check("rst_sum", {28'd0, bus.sum}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
      reset_n = 1'b1;
      @(posedge clk); #1;

      op_timed(4'd3, 4'd5, 4'd8, 1'b0);
      op_timed(4'd9, 4'd9, 4'd2, 1'b1);
      op_timed(4'd12, 4'd7, 4'd3, 1'b1);

      // Stall in DONE with a new operand pair already offered.
      bus.out_ready = 1'b0;
      issue(4'd2, 4'd4, 4'd6, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_reached", {31'd0, bus.out_valid}, 32'd1);
      bus.op_a     = 4'd1;
      bus.op_b     = 4'd1;
      bus.in_valid = 1'b1;
      exp_q.push_back({1'b0, 4'd2});
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("stall_sum_stable", {28'd0, bus.sum}, 32'd6);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_before_accept", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      check("accepted_after_idle", {31'd0, bus.in_ready}, 32'd0);
      bus.in_valid = 1'b0;
      drain();

      // Reset during the second SHIFT cycle discards the operation.
      bus.op_a     = 4'd7;
      bus.op_b     = 4'd7;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_shift_add_ctrl", {31'd0, add_ctrl}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("midrst_add_ctrl", {31'd0, add_ctrl}, 32'd0);
      check("midrst_sum", {28'd0, bus.sum}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      ov_any = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         ov_any = ov_any | bus.out_valid;
      end
      check("no_out_after_reset", {31'd0, ov_any}, 32'd0);
      @(posedge clk); #1;
      op_timed(4'd15, 4'd1, 4'd0, 1'b1);

      // Back-to-back with in_valid and out_ready held high.
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.op_a = va[i];
         bus.op_b = vb[i];
         wait_ready();
         exp_q.push_back({vo[i], vs[i]});
         @(posedge clk); #1;
         t_acc[i] = cyc;
      end
      bus.in_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         check("b2b_spacing", t_acc[i] - t_acc[i-1], 32'd8);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width; SHALL equal the serial adder's width; legal range WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  controller can accept an operand pair.
REQ-006 op_a, op_b  input  WIDTH each  unsigned operands.
REQ-007 out_valid  output  1  sum available.
REQ-008 out_ready  input  1  consumer takes the sum.
REQ-009 sum  output  WIDTH  registered result.
REQ-010 ovf  output  1  unsigned carry-out of the addition; present only with SERIAL_ADD_OVF_EN.
REQ-011 add_ctrl  output  1  drives the adder's ctrl: 0 = parallel load and carry clear, 1 = shift/add.
REQ-012 add_a, add_b  output  WIDTH each  parallel load values to the adder.
REQ-013 add_result  input  WIDTH  adder register A contents.

Function
REQ-014 FSM states: IDLE, LOAD, SHIFT, CAPT, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, register op_a/op_b into a_q/b_q and go to LOAD.
REQ-016 LOAD (1 cycle): add_ctrl=0; clear the bit counter; go to SHIFT.
REQ-017 SHIFT (exactly WIDTH cycles): add_ctrl=1; increment the counter each cycle; leave for CAPT when counter==WIDTH-1.
REQ-018 CAPT (1 cycle): add_ctrl=0; sample add_result into sum at the end of the cycle; go to DONE.
REQ-019 DONE: out_valid=1; sum and ovf held stable; on out_ready go to IDLE.
REQ-020 add_a=a_q and add_b=b_q in all states; add_ctrl=0 in IDLE, LOAD, CAPT and DONE.
REQ-021 Latency: out_valid rises WIDTH+2 cycles after the accepting edge (6 for WIDTH=4).
REQ-022 in_ready=0 outside IDLE; in_valid is ignored while busy; operands never change mid-operation.
REQ-023 Minimum spacing between accepts is WIDTH+4 cycles with out_ready held high.
REQ-024 The counter width is $clog2(WIDTH) bits minimum, and the counter never wraps inside SHIFT.
REQ-025 sum is result modulo 2^WIDTH.

Reset
REQ-026 reset_n low at any time, including mid-SHIFT: state=IDLE, counter=0, a_q=b_q=0, sum=0, ovf=0, out_valid=0, add_ctrl=0, in_ready=1.
REQ-027 An in-flight operation is discarded on reset, and no out_valid pulse is produced for it.

Configuration
REQ-028 Macro SERIAL_ADD_OVF_EN defined: the ovf port exists and is registered in CAPT as (a_q[MSB]&b_q[MSB]) | ((a_q[MSB]|b_q[MSB]) & ~add_result[MSB]).
REQ-029 Macro undefined: there is no ovf port and no ovf logic; all other behaviour is identical.

Structure
REQ-030 Package serial_add_pkg SHALL hold the FSM state enum and the default-width constant; the controller SHALL import it.
REQ-031 No internal sub-module: the counter and FSM are inline.
REQ-032 The adder is external; the integration wrapper serial_add_top SHALL instantiate serial_add_ctrl and serial_adder with matching WIDTH.

Verification (WIDTH=4, with the real adder attached)
REQ-033 Reset: assert reset_n=0 -> in_ready=1, out_valid=0, add_ctrl=0, sum=0.
REQ-034 Accept 3+5 -> add_ctrl=0 for 1 cycle, then 1 for 4 cycles, then 0; out_valid on cycle 6; sum=8, ovf=0.
REQ-035 Accept 9+9 with SERIAL_ADD_OVF_EN -> sum=2, ovf=1.
REQ-036 Hold out_ready=0 for 3 cycles in DONE while driving in_valid with 1+1 -> sum stays stable, in_ready=0, and 1+1 is accepted only after returning to IDLE.
REQ-037 Pulse reset_n low during the 2nd SHIFT cycle of 7+7 -> no out_valid; the next op 15+1 gives sum=0, ovf=1.
REQ-038 Drive back-to-back ops with in_valid and out_ready held high -> accepts are exactly 8 cycles apart, and each sum is correct.
